// File: rtl/trap_ctrl.sv
// Trap / mret sequencer: on a faulting or trapping decode-stage instruction it latches
// the cause, pulses a commit strobe to the CSR file, squashes the pipe and redirects the PC.
// Latency: event accept -> redirect strobe is FLUSH_CYCLES+2 cycles. Backpressure: stall is
// held from COMMIT through REDIRECT, and inputs are ignored until IDLE is re-entered.
//
// Ports:
//   clk, reset                  : clock, async active-high reset
//   inst_valid, pc, inst        : decode-stage instruction
//   illegal_inst..mret_inst     : decoder flags
//   *_misaligned, mem_addr      : fault flags and effective load/store address
//   now_priv_mode               : current privilege (00 U, 11 M)
//   mtvec_in, mepc_in           : current CSR values, sampled in REDIRECT
//   exception_from_inst, mret   : one-cycle commit pulses
//   mcause_out/mepc_out/mtval_out : latched trap info
//   stall, flush                : pipeline hold / squash
//   redirect, redirect_pc       : one-cycle PC redirect strobe and target

module trap_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_valid,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    input  logic        illegal_inst,
    input  logic        ecall,
    input  logic        ebreak,
    input  logic        mret_inst,
    input  logic        iaddr_misaligned,
    input  logic        load_misaligned,
    input  logic        store_misaligned,
    input  logic [31:0] mem_addr,
    input  logic [1:0]  now_priv_mode,
    input  logic [31:0] mtvec_in,
    input  logic [31:0] mepc_in,
    output logic        exception_from_inst,
    output logic        mret,
    output logic [3:0]  mcause_out,
    output logic [31:0] mepc_out,
    output logic [31:0] mtval_out,
    output logic        stall,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COMMIT   = 2'd1,
        S_FLUSH    = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic        r_is_mret;
    logic [3:0]  r_cause;
    logic [31:0] r_mepc;
    logic [31:0] r_mtval;

    logic        w_mret_ill;
    logic        w_exc;
    logic        w_mret_ok;
    logic        w_event;
    logic [3:0]  w_cause;
    logic [31:0] w_tval;

    // mret is only legal in M-mode; from any other privilege it traps as illegal.
    assign w_mret_ill = mret_inst && (now_priv_mode != 2'b11);
    assign w_exc      = iaddr_misaligned | illegal_inst | w_mret_ill | ebreak | ecall
                      | store_misaligned | load_misaligned;
    // Any exception flag alongside mret suppresses the mret path.
    assign w_mret_ok  = mret_inst && !w_exc;
    assign w_event    = inst_valid && (w_exc || w_mret_ok);

    // Cause and trap value, highest priority first.
    always_comb begin
        w_cause = 4'd0;
        w_tval  = 32'h0;
        if (iaddr_misaligned) begin
            w_cause = 4'd0;
            w_tval  = pc;
        end else if (illegal_inst || w_mret_ill) begin
            w_cause = 4'd2;
            w_tval  = inst;
        end else if (ebreak) begin
            w_cause = 4'd3;
            w_tval  = pc;
        end else if (ecall) begin
            w_cause = (now_priv_mode == 2'b00) ? 4'd8 : 4'd11;
            w_tval  = 32'h0;
        end else if (store_misaligned) begin
            w_cause = 4'd6;
            w_tval  = mem_addr;
        end else if (load_misaligned) begin
            w_cause = 4'd4;
            w_tval  = mem_addr;
        end
    end

    // State register plus the data latched at event accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_is_mret <= 1'b0;
            r_cause   <= 4'd0;
            r_mepc    <= 32'h0;
            r_mtval   <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_event) begin
                r_cnt     <= 4'(FLUSH_CYCLES);
                r_is_mret <= w_mret_ok;
                r_cause   <= w_mret_ok ? 4'd0 : w_cause;
                r_mepc    <= pc;
                r_mtval   <= w_mret_ok ? 32'h0 : w_tval;
            end else if (r_state == S_FLUSH && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Next-state logic. FLUSH leaves when the count reaches zero, so it lasts
    // exactly FLUSH_CYCLES cycles.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_event) w_state_nxt = S_COMMIT;
            S_COMMIT:   w_state_nxt = S_FLUSH;
            S_FLUSH:    if (r_cnt <= 4'd1) w_state_nxt = S_REDIRECT;
            S_REDIRECT: w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        exception_from_inst = 1'b0;
        mret                = 1'b0;
        stall               = 1'b0;
        flush               = 1'b0;
        redirect            = 1'b0;
        redirect_pc         = 32'h0;
        case (r_state)
            S_COMMIT: begin
                stall               = 1'b1;
                exception_from_inst = !r_is_mret;
                mret                = r_is_mret;
            end
            S_FLUSH: begin
                stall = 1'b1;
                flush = 1'b1;
            end
            S_REDIRECT: begin
                stall       = 1'b1;
                redirect    = 1'b1;
                redirect_pc = r_is_mret ? mepc_in : (mtvec_in & ~32'h3);
            end
            default: ;
        endcase
    end

    assign mcause_out = r_cause;
    assign mepc_out   = r_mepc;
    assign mtval_out  = r_mtval;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: two instances (FLUSH_CYCLES 2 and 5) share stimulus; a behavioural
// model predicts cause/tval/path and the per-cycle strobe timeline for each.
// Directed cases first, then randomized events with noise on inputs while busy.

module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_valid;
    logic [31:0] pc, inst, mem_addr, mtvec_in, mepc_in;
    logic        illegal_inst, ecall, ebreak, mret_inst;
    logic        iaddr_misaligned, load_misaligned, store_misaligned;
    logic [1:0]  now_priv_mode;

    logic        a_exc, a_mret, a_stall, a_flush, a_rd;
    logic [3:0]  a_mcause;
    logic [31:0] a_mepc, a_mtval, a_rpc;
    logic        b_exc, b_mret, b_stall, b_flush, b_rd;
    logic [3:0]  b_mcause;
    logic [31:0] b_mepc, b_mtval, b_rpc;

    int n_chk  = 0;
    int n_fail = 0;

    // expected event description from the model
    int          e_path;   // 0 none, 1 exception, 2 mret
    logic [3:0]  e_cause;
    logic [31:0] e_tval, e_pc, e_mtvec, e_mepc;

    always #5 clk = ~clk;

    trap_ctrl #(.FLUSH_CYCLES(2)) u_dut_a (
        .clk(clk), .reset(reset), .inst_valid(inst_valid), .pc(pc), .inst(inst),
        .illegal_inst(illegal_inst), .ecall(ecall), .ebreak(ebreak), .mret_inst(mret_inst),
        .iaddr_misaligned(iaddr_misaligned), .load_misaligned(load_misaligned),
        .store_misaligned(store_misaligned), .mem_addr(mem_addr), .now_priv_mode(now_priv_mode),
        .mtvec_in(mtvec_in), .mepc_in(mepc_in),
        .exception_from_inst(a_exc), .mret(a_mret), .mcause_out(a_mcause), .mepc_out(a_mepc),
        .mtval_out(a_mtval), .stall(a_stall), .flush(a_flush), .redirect(a_rd),
        .redirect_pc(a_rpc)
    );

    trap_ctrl #(.FLUSH_CYCLES(5)) u_dut_b (
        .clk(clk), .reset(reset), .inst_valid(inst_valid), .pc(pc), .inst(inst),
        .illegal_inst(illegal_inst), .ecall(ecall), .ebreak(ebreak), .mret_inst(mret_inst),
        .iaddr_misaligned(iaddr_misaligned), .load_misaligned(load_misaligned),
        .store_misaligned(store_misaligned), .mem_addr(mem_addr), .now_priv_mode(now_priv_mode),
        .mtvec_in(mtvec_in), .mepc_in(mepc_in),
        .exception_from_inst(b_exc), .mret(b_mret), .mcause_out(b_mcause), .mepc_out(b_mepc),
        .mtval_out(b_mtval), .stall(b_stall), .flush(b_flush), .redirect(b_rd),
        .redirect_pc(b_rpc)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Behavioural model of which trap (if any) an instruction raises.
    task automatic model(input logic iv, input logic [31:0] p, input logic [31:0] ins,
                         input logic ill, input logic ec, input logic eb, input logic mr,
                         input logic ia, input logic lm, input logic sm,
                         input logic [31:0] addr, input logic [1:0] priv);
        logic mr_bad;
        mr_bad  = mr && (priv != 2'b11);
        e_path  = 0;
        e_cause = 4'd0;
        e_tval  = 32'h0;
        e_pc    = p;
        if (!iv)                begin e_path = 0; end
        else if (ia)            begin e_path = 1; e_cause = 4'd0; e_tval = p;    end
        else if (ill || mr_bad) begin e_path = 1; e_cause = 4'd2; e_tval = ins;  end
        else if (eb)            begin e_path = 1; e_cause = 4'd3; e_tval = p;    end
        else if (ec)            begin e_path = 1; e_cause = (priv == 2'b00) ? 4'd8 : 4'd11; end
        else if (sm)            begin e_path = 1; e_cause = 4'd6; e_tval = addr; end
        else if (lm)            begin e_path = 1; e_cause = 4'd4; e_tval = addr; end
        else if (mr)            begin e_path = 2; end
    endtask

    // k = cycles since the accepting edge; nfl = flush length of the instance.
    task automatic check_cycle(input string who, input int nfl, input int k,
                               input logic exc, input logic mr, input logic [3:0] mc,
                               input logic [31:0] mepc, input logic [31:0] mtval,
                               input logic st, input logic fl, input logic rd,
                               input logic [31:0] rpc);
        bit busy;
        busy = (e_path != 0) && (k <= nfl + 2);
        chk($sformatf("%s k%0d stall", who, k), 32'(st), 32'(busy));
        chk($sformatf("%s k%0d exc", who, k), 32'(exc), 32'(e_path == 1 && k == 1));
        chk($sformatf("%s k%0d mret", who, k), 32'(mr), 32'(e_path == 2 && k == 1));
        chk($sformatf("%s k%0d flush", who, k), 32'(fl),
            32'(e_path != 0 && k >= 2 && k <= nfl + 1));
        chk($sformatf("%s k%0d redirect", who, k), 32'(rd), 32'(e_path != 0 && k == nfl + 2));
        if (e_path != 0 && k == nfl + 2)
            chk($sformatf("%s redirect_pc", who), rpc,
                (e_path == 1) ? {e_mtvec[31:2], 2'b00} : e_mepc);
        if (e_path == 1 && busy) begin
            chk($sformatf("%s k%0d mcause", who, k), 32'(mc), 32'(e_cause));
            chk($sformatf("%s k%0d mepc", who, k), mepc, e_pc);
            chk($sformatf("%s k%0d mtval", who, k), mtval, e_tval);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " a strobes"}, {27'h0, a_exc, a_mret, a_stall, a_flush, a_rd}, 32'h0);
        chk({tag, " a mcause"}, 32'(a_mcause), 32'h0);
        chk({tag, " a mepc"}, a_mepc, 32'h0);
        chk({tag, " a mtval"}, a_mtval, 32'h0);
        chk({tag, " a rpc"}, a_rpc, 32'h0);
        chk({tag, " b strobes"}, {27'h0, b_exc, b_mret, b_stall, b_flush, b_rd}, 32'h0);
        chk({tag, " b mcause"}, 32'(b_mcause), 32'h0);
        chk({tag, " b mepc"}, b_mepc, 32'h0);
        chk({tag, " b mtval"}, b_mtval, 32'h0);
        chk({tag, " b rpc"}, b_rpc, 32'h0);
    endtask

    task automatic clear_inputs();
        inst_valid = 0; illegal_inst = 0; ecall = 0; ebreak = 0; mret_inst = 0;
        iaddr_misaligned = 0; load_misaligned = 0; store_misaligned = 0;
    endtask

    // Called at a negedge with both instances idle. Drives one instruction, then
    // follows both instances for 8 cycles while throwing noise at the inputs.
    task automatic run_event(input logic iv, input logic [31:0] p, input logic [31:0] ins,
                             input logic ill, input logic ec, input logic eb, input logic mr,
                             input logic ia, input logic lm, input logic sm,
                             input logic [31:0] addr, input logic [1:0] priv,
                             input logic [31:0] tvec, input logic [31:0] epc);
        inst_valid = iv; pc = p; inst = ins; illegal_inst = ill; ecall = ec; ebreak = eb;
        mret_inst = mr; iaddr_misaligned = ia; load_misaligned = lm; store_misaligned = sm;
        mem_addr = addr; now_priv_mode = priv; mtvec_in = tvec; mepc_in = epc;
        model(iv, p, ins, ill, ec, eb, mr, ia, lm, sm, addr, priv);
        e_mtvec = tvec;
        e_mepc  = epc;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check_cycle("A", 2, k, a_exc, a_mret, a_mcause, a_mepc, a_mtval,
                        a_stall, a_flush, a_rd, a_rpc);
            check_cycle("B", 5, k, b_exc, b_mret, b_mcause, b_mepc, b_mtval,
                        b_stall, b_flush, b_rd, b_rpc);
            // Noise that must be ignored while both instances are busy.
            inst_valid       = (e_path != 0 && k <= 3) ? 1'($urandom) : 1'b0;
            illegal_inst     = 1'($urandom); ecall = 1'($urandom); ebreak = 1'($urandom);
            mret_inst        = 1'($urandom); iaddr_misaligned = 1'($urandom);
            load_misaligned  = 1'($urandom); store_misaligned = 1'($urandom);
            pc = $urandom; inst = $urandom; mem_addr = $urandom;
            now_priv_mode = 2'($urandom);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        pc = 0; inst = 0; mem_addr = 0; now_priv_mode = 2'b11; mtvec_in = 0; mepc_in = 0;
        e_path = 0; e_cause = 0; e_tval = 0; e_pc = 0; e_mtvec = 0; e_mepc = 0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        // illegal instruction, mtvec low bits masked
        run_event(1, 32'h100, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 0, 32'h0, 2'b11, 32'h203, 32'h0);
        // ecall U then M
        run_event(1, 32'h40, 32'h73, 0, 1, 0, 0, 0, 0, 0, 32'h0, 2'b00, 32'h400, 32'h0);
        run_event(1, 32'h40, 32'h73, 0, 1, 0, 0, 0, 0, 0, 32'h0, 2'b11, 32'h400, 32'h0);
        // mret in M, then in U
        run_event(1, 32'h60, 32'h3020_0073, 0, 0, 0, 1, 0, 0, 0, 32'h0, 2'b11, 32'h400, 32'h84);
        run_event(1, 32'h60, 32'h3020_0073, 0, 0, 0, 1, 0, 0, 0, 32'h0, 2'b00, 32'h400, 32'h84);
        // illegal + load misaligned + mret together
        run_event(1, 32'h70, 32'h1234_5678, 1, 0, 0, 1, 0, 1, 0, 32'h1001, 2'b11, 32'h500, 32'h84);
        // store/load misaligned, iaddr misaligned, and flags without inst_valid
        run_event(1, 32'h80, 32'h0, 0, 0, 0, 0, 0, 0, 1, 32'h2003, 2'b00, 32'h600, 32'h0);
        run_event(1, 32'h84, 32'h0, 0, 0, 0, 0, 0, 1, 0, 32'h2005, 2'b00, 32'h600, 32'h0);
        run_event(1, 32'h86, 32'h0, 0, 1, 1, 0, 1, 1, 1, 32'h2005, 2'b11, 32'h600, 32'h0);
        run_event(0, 32'h90, 32'h0, 1, 1, 1, 1, 1, 1, 1, 32'h0, 2'b11, 32'h600, 32'h0);

        // reset during the second flush cycle of the short instance
        inst_valid = 1; pc = 32'h200; inst = 32'hFFFF_FFFF; illegal_inst = 1;
        mtvec_in = 32'h700; now_priv_mode = 2'b11;
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        chk("pre-reset a flush", 32'(a_flush), 32'h1);
        reset = 1'b1;
        #1;
        check_zero("mid-flush reset");
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post-reset a redirect", 32'(a_rd), 32'h0);
            chk("post-reset b stall", 32'(b_stall), 32'h0);
        end
        run_event(1, 32'h8, 32'h0010_0073, 0, 0, 1, 0, 0, 0, 0, 32'h0, 2'b11, 32'h800, 32'h0);

        // randomized events
        for (int n = 0; n < 200; n++) begin
            logic [31:0] r;
            r = $urandom;
            run_event(r[0] | r[1], $urandom, $urandom,
                      r[4:2] == 0, r[7:5] == 0, r[10:8] == 0, r[12:11] == 0,
                      r[15:13] == 0, r[18:16] == 0, r[21:19] == 0,
                      $urandom, r[23:22], $urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter: FLUSH_CYCLES, 2, number of flush cycles between trap/mret commit and redirect (legal range 1..15).
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: inst_valid  in  1  decode-stage instruction valid this cycle.
REQ-005 Port: pc  in  32  address of the decode-stage instruction.
REQ-006 Port: inst  in  32  raw instruction word.
REQ-007 Port: illegal_inst, ecall, ebreak, mret_inst  in  1 each  decoder flags.
REQ-008 Port: iaddr_misaligned, load_misaligned, store_misaligned  in  1 each  fault flags.
REQ-009 Port: mem_addr  in  32  effective load/store address.
REQ-010 Port: now_priv_mode  in  2  current privilege (2'b00 U, 2'b11 M).
REQ-011 Port: mtvec_in, mepc_in  in  32 each  current CSR values.
REQ-012 Port: exception_from_inst, mret  out  1 each  single-cycle commit pulses to the CSR file.
REQ-013 Port: mcause_out  out  4  cause code; mepc_out, mtval_out  out  32 each.
REQ-014 Port: stall, flush  out  1 each  pipeline hold and squash.
REQ-015 Port: redirect  out  1  one-cycle PC redirect strobe; redirect_pc  out  32  target.

Function
REQ-016 FSM states: IDLE, COMMIT, FLUSH, REDIRECT; state held in one registered variable.
REQ-017 IDLE: event = inst_valid AND any fault/decoder flag; no event -> stay IDLE, all strobes 0.
REQ-018 Cause priority (highest first): iaddr_misaligned=0, illegal_inst=2, ebreak=3, ecall=8 (U) / 11 (M), store_misaligned=6, load_misaligned=4.
REQ-019 ecall with now_priv_mode other than 2'b00 or 2'b11 -> cause 11.
REQ-020 mret_inst in U-mode -> illegal_inst trap (cause 2); mret_inst in M-mode with no other flag -> mret path.
REQ-021 Any exception flag concurrent with mret_inst -> exception path wins; mret is not taken.
REQ-022 On event, latch cause, mepc_out=pc, and mtval: illegal->inst, iaddr_misaligned/ebreak->pc, load/store misaligned->mem_addr, ecall->0; IDLE->COMMIT.
REQ-023 COMMIT (exactly 1 cycle): exception path pulses exception_from_inst; mret path pulses mret; then -> FLUSH.
REQ-024 mcause_out, mepc_out, mtval_out stable from COMMIT through REDIRECT.
REQ-025 FLUSH: flush=1 for exactly FLUSH_CYCLES cycles, 4-bit down-counter loaded on COMMIT entry; at count 0 -> REDIRECT.
REQ-026 REDIRECT (1 cycle): redirect=1; redirect_pc = {mtvec_in[31:2],2'b00} for exceptions, mepc_in for mret, sampled this cycle; -> IDLE.
REQ-027 stall=1 in COMMIT, FLUSH, REDIRECT; 0 in IDLE.
REQ-028 Inputs ignored outside IDLE; no new event accepted until IDLE is re-entered.
REQ-029 Total latency event-accept -> redirect strobe = FLUSH_CYCLES+2 cycles.

Reset
REQ-030 reset asserted at any time, including mid-FLUSH: immediately state=IDLE, counter=0, all outputs 0 (buses 32'h0, mcause_out 4'h0).
REQ-031 First event accepted on the first rising clk edge after reset deasserts.

Verification
REQ-032 Illegal inst: pc=0x100, inst=0xFFFFFFFF, illegal_inst=1, mtvec_in=0x203 -> exception_from_inst pulse 1 cycle later, mcause=2, mepc=0x100, mtval=0xFFFFFFFF, flush 2 cycles, redirect_pc=0x200 at cycle 4.
REQ-033 U-mode ecall, pc=0x40 -> mcause=8, mtval=0; repeat in M-mode -> mcause=11.
REQ-034 mret_inst in M-mode, mepc_in=0x84 -> mret pulse, no exception_from_inst, redirect_pc=0x84; same in U-mode -> mcause=2.
REQ-035 Simultaneous illegal_inst+load_misaligned+mret_inst, mem_addr=0x1001 -> mcause=2 only, no mret pulse.
REQ-036 reset pulsed during second FLUSH cycle -> all outputs 0 next sample, no redirect; new ebreak at pc=0x8 afterward -> mcause=3, mtval=0x8.
REQ-037 FLUSH_CYCLES=5 build -> flush high exactly 5 cycles, stall high 7 cycles per trap.
